// File: rtl/spi_adc_avg_if.sv
// SPI pin bundle shared by the ADC reader (master) and the ADCs (slave).
// One common CS/SCK pair fans out to NUM_CH converters, each with its own MISO line.
interface spi_adc_avg_if #(
    parameter int NUM_CH = 2
);
    logic              spi_cs_no;
    logic              spi_sck_o;
    logic [NUM_CH-1:0] spi_miso_i;

    modport master (
        output spi_cs_no,
        output spi_sck_o,
        input  spi_miso_i
    );

    modport slave (
        input  spi_cs_no,
        input  spi_sck_o,
        output spi_miso_i
    );
endinterface

// File: rtl/spi_adc_avg.sv
// Multi-channel SPI ADC reader with 2^k frame averaging and leading-bit error flagging.
// Every frame is LEAD_W leading zeros followed by DATA_W data bits, MSB first.
// Each completed block publishes the truncated average per channel with a one-cycle pulse.
// LEAD_W must be at least 1 and AVG_LOG2_MAX at least 1.
module spi_adc_avg #(
    parameter int  NUM_CH       = 2,
    parameter int  DATA_W       = 12,
    parameter int  LEAD_W       = 4,
    parameter int  CLK_DIV      = 4,
    parameter int  CS_GAP       = 4,
    parameter int  AVG_LOG2_MAX = 3,
    localparam int AVG_W        = $clog2(AVG_LOG2_MAX + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_i,
    input  logic                     mode_i,
    input  logic                     start_i,
    input  logic [AVG_W-1:0]         avg_log2_i,
    spi_adc_avg_if.master            spi,
    output logic                     busy_o,
    output logic                     data_update_o,
    output logic [NUM_CH*DATA_W-1:0] data_o,
    output logic                     frame_err_o
);
    localparam int FRAME_W = LEAD_W + DATA_W;
    localparam int ACC_W   = DATA_W + AVG_LOG2_MAX;
    localparam int FC_W    = AVG_LOG2_MAX + 1;
    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(FRAME_W + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    logic [1:0]                     state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [BIT_W-1:0]               bitCnt_q, bitCnt_d;
    logic                           cs_q, cs_d;
    logic                           sck_q, sck_d;
    logic [NUM_CH-1:0][FRAME_W-1:0] shReg_q, shReg_d;
    logic [NUM_CH-1:0][ACC_W-1:0]   acc_q, acc_d;
    logic [FC_W-1:0]                frameCnt_q, frameCnt_d;
    logic [AVG_W-1:0]               k_q, k_d;
    logic                           blkErr_q, blkErr_d;
    logic                           blkDone_q, blkDone_d;
    logic                           busy_q, busy_d;
    logic                           update_q, update_d;
    logic                           frameErr_q, frameErr_d;
    logic [NUM_CH*DATA_W-1:0]       data_q, data_d;

    logic [NUM_CH-1:0][ACC_W-1:0]   accSum;
    logic [NUM_CH-1:0][DATA_W-1:0]  accAvg;
    logic                           leadErr;
    logic [FC_W-1:0]                frameCntInc;
    logic [FC_W-1:0]                blockTarget;
    logic                           blockFull;
    logic                           blockDoneNow;
    logic                           startReq;
    logic [AVG_W-1:0]               kClamp;

    // Datapath helpers: the just-finished frame folded into the accumulators, and block bookkeeping
    always_comb begin
        leadErr = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            accSum[c] = acc_q[c] + ACC_W'(shReg_q[c][DATA_W-1:0]);
            accAvg[c] = DATA_W'(accSum[c] >> k_q);
            leadErr   = leadErr | (|shReg_q[c][FRAME_W-1:DATA_W]);
        end
        frameCntInc  = frameCnt_q + FC_W'(1);
        blockTarget  = FC_W'(1) << k_q;
        blockFull    = (frameCntInc == blockTarget);
        blockDoneNow = (cnt_q == '0) ? blockFull : blkDone_q;
        startReq     = en_i && (!mode_i || start_i);
        kClamp       = (avg_log2_i > AVG_W'(AVG_LOG2_MAX)) ? AVG_W'(AVG_LOG2_MAX) : avg_log2_i;
    end

    // Frame sequencer and block accumulation: decides the next value of every register
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitCnt_d   = bitCnt_q;
        cs_d       = cs_q;
        sck_d      = sck_q;
        shReg_d    = shReg_q;
        acc_d      = acc_q;
        frameCnt_d = frameCnt_q;
        k_d        = k_q;
        blkErr_d   = blkErr_q;
        blkDone_d  = blkDone_q;
        busy_d     = busy_q;
        update_d   = 1'b0;
        frameErr_d = frameErr_q;
        data_d     = data_q;

        case (state_q)
            IDLE: begin
                if (startReq) begin
                    state_d    = SETUP;
                    cs_d       = 1'b0;
                    sck_d      = 1'b1;
                    cnt_d      = '0;
                    k_d        = kClamp;
                    frameCnt_d = '0;
                    acc_d      = '0;
                    blkErr_d   = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    state_d  = SHIFT;
                    sck_d    = 1'b0;
                    cnt_d    = '0;
                    bitCnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        for (int c = 0; c < NUM_CH; c++) begin
                            shReg_d[c] = {shReg_q[c][FRAME_W-2:0], spi.spi_miso_i[c]};
                        end
                    end else if (bitCnt_q == BIT_W'(FRAME_W - 1)) begin
                        cs_d    = 1'b1;
                        state_d = GAP;
                    end else begin
                        sck_d    = 1'b0;
                        bitCnt_d = bitCnt_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    if (blockFull) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            data_d[c*DATA_W +: DATA_W] = accAvg[c];
                        end
                        frameErr_d = blkErr_q | leadErr;
                        update_d   = 1'b1;
                        acc_d      = '0;
                        blkErr_d   = 1'b0;
                        frameCnt_d = '0;
                        blkDone_d  = 1'b1;
                    end else begin
                        acc_d      = accSum;
                        blkErr_d   = blkErr_q | leadErr;
                        frameCnt_d = frameCntInc;
                        blkDone_d  = 1'b0;
                    end
                end
                if (cnt_q == CNT_W'(CS_GAP - 1)) begin
                    cnt_d = '0;
                    if (!blockDoneNow && en_i) begin
                        state_d = SETUP;
                        cs_d    = 1'b0;
                    end else if (blockDoneNow && en_i && !mode_i) begin
                        state_d = SETUP;
                        cs_d    = 1'b0;
                        k_d     = kClamp;
                    end else begin
                        state_d    = IDLE;
                        busy_d     = 1'b0;
                        acc_d      = '0;
                        blkErr_d   = 1'b0;
                        frameCnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // State registers; reset returns the SPI lines to idle-high immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bitCnt_q   <= '0;
            cs_q       <= 1'b1;
            sck_q      <= 1'b1;
            shReg_q    <= '0;
            acc_q      <= '0;
            frameCnt_q <= '0;
            k_q        <= '0;
            blkErr_q   <= 1'b0;
            blkDone_q  <= 1'b0;
            busy_q     <= 1'b0;
            update_q   <= 1'b0;
            frameErr_q <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitCnt_q   <= bitCnt_d;
            cs_q       <= cs_d;
            sck_q      <= sck_d;
            shReg_q    <= shReg_d;
            acc_q      <= acc_d;
            frameCnt_q <= frameCnt_d;
            k_q        <= k_d;
            blkErr_q   <= blkErr_d;
            blkDone_q  <= blkDone_d;
            busy_q     <= busy_d;
            update_q   <= update_d;
            frameErr_q <= frameErr_d;
            data_q     <= data_d;
        end
    end

    assign spi.spi_cs_no  = cs_q;
    assign spi.spi_sck_o  = sck_q;
    assign busy_o         = busy_q;
    assign data_update_o  = update_q;
    assign data_o         = data_q;
    assign frame_err_o    = frameErr_q;
endmodule

// File: tb/tb_spi_adc_avg.sv
// Self-checking bench for spi_adc_avg: behavioural ADCs on the SPI bus plus a block-average model.
module tb_spi_adc_avg;
    localparam int NUM_CH       = 2;
    localparam int DATA_W       = 12;
    localparam int LEAD_W       = 4;
    localparam int CLK_DIV      = 4;
    localparam int CS_GAP       = 4;
    localparam int AVG_LOG2_MAX = 2;
    localparam int AVG_W        = $clog2(AVG_LOG2_MAX + 1);
    localparam int FRAME_W      = LEAD_W + DATA_W;
    localparam int CS_LOW_CLK   = CLK_DIV + FRAME_W * 2 * CLK_DIV;

    typedef logic [NUM_CH-1:0][FRAME_W-1:0] frame_t;
    typedef logic [NUM_CH-1:0][DATA_W-1:0]  chData_t;
    typedef logic [NUM_CH-1:0][LEAD_W-1:0]  chLead_t;
    typedef logic [NUM_CH*DATA_W-1:0]       data_t;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             mode;
    logic             start;
    logic [AVG_W-1:0] avgLog2;
    logic             busy;
    logic             dataUpdate;
    logic             frameErr;
    data_t            dataOut;

    spi_adc_avg_if #(.NUM_CH(NUM_CH)) spiBus ();

    spi_adc_avg #(
        .NUM_CH      (NUM_CH),
        .DATA_W      (DATA_W),
        .LEAD_W      (LEAD_W),
        .CLK_DIV     (CLK_DIV),
        .CS_GAP      (CS_GAP),
        .AVG_LOG2_MAX(AVG_LOG2_MAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en),
        .mode_i       (mode),
        .start_i      (start),
        .avg_log2_i   (avgLog2),
        .spi          (spiBus),
        .busy_o       (busy),
        .data_update_o(dataUpdate),
        .data_o       (dataOut),
        .frame_err_o  (frameErr)
    );

    int     assertCount = 0;
    int     failCount   = 0;
    frame_t txQ[$];
    frame_t curFrame;
    int     fallIdx     = 0;
    int     csFalls     = 0;
    data_t  updData[$];
    logic   updErr[$];
    int     updCount    = 0;
    int     csLowCnt    = 0;
    int     lastCsLow   = 0;
    int     sckRises    = 0;
    int     lastRises   = 0;
    logic   prevSck     = 1'b1;
    data_t  expData[$];
    logic   expErr[$];
    data_t  lastExpData = '0;
    int     blkSum[NUM_CH];
    logic   blkErr;
    int     blkFrames;
    int     modelK;
    int     framesPushed;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ADC model: a new frame is loaded on CS fall, and each SCK fall presents the next bit MSB first
    always @(negedge spiBus.spi_cs_no) begin
        if (txQ.size() > 0) curFrame = txQ.pop_front();
        else curFrame = '0;
        fallIdx = 0;
        csFalls++;
    end

    always @(negedge spiBus.spi_sck_o) begin
        if (!spiBus.spi_cs_no) begin
            for (int c = 0; c < NUM_CH; c++) begin
                spiBus.spi_miso_i[c] = (fallIdx < FRAME_W) ? curFrame[c][FRAME_W-1-fallIdx] : 1'b0;
            end
            fallIdx++;
        end
    end

    // Bus monitor: measures CS-low length and SCK rises per frame, and captures every published result
    always @(negedge clk) begin
        if (!spiBus.spi_cs_no) begin
            csLowCnt++;
            if (spiBus.spi_sck_o && !prevSck) sckRises++;
        end else if (csLowCnt != 0) begin
            lastCsLow = csLowCnt;
            lastRises = sckRises;
            csLowCnt  = 0;
            sckRises  = 0;
        end
        prevSck = spiBus.spi_sck_o;
        if (dataUpdate) begin
            updData.push_back(dataOut);
            updErr.push_back(frameErr);
            updCount++;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic frame_t mkFrame(input chLead_t lead, input chData_t d);
        frame_t f;
        for (int c = 0; c < NUM_CH; c++) f[c] = {lead[c], d[c]};
        return f;
    endfunction

    function automatic chData_t rndData();
        chData_t d;
        for (int c = 0; c < NUM_CH; c++) d[c] = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
        return d;
    endfunction

    function automatic chLead_t rndLead();
        chLead_t l;
        for (int c = 0; c < NUM_CH; c++)
            l[c] = ($urandom_range(0, 3) == 0) ? LEAD_W'($urandom_range(1, (1 << LEAD_W) - 1)) : '0;
        return l;
    endfunction

    // Reference model: start a fresh run with averaging exponent min(k, AVG_LOG2_MAX)
    task automatic setK(input int kReq);
        modelK       = (kReq > AVG_LOG2_MAX) ? AVG_LOG2_MAX : kReq;
        framesPushed = 0;
        blkFrames    = 0;
        blkErr       = 1'b0;
        for (int c = 0; c < NUM_CH; c++) blkSum[c] = 0;
        expData.delete();
        expErr.delete();
    endtask

    // Reference model: queue a frame for the ADCs and predict the block result once 2^k frames are in
    task automatic pushFrame(input frame_t f);
        data_t d;
        txQ.push_back(f);
        framesPushed++;
        for (int c = 0; c < NUM_CH; c++) begin
            blkSum[c] += int'(f[c][DATA_W-1:0]);
            if (f[c][FRAME_W-1:DATA_W] != '0) blkErr = 1'b1;
        end
        blkFrames++;
        if (blkFrames == (1 << modelK)) begin
            d = '0;
            for (int c = 0; c < NUM_CH; c++) d[c*DATA_W +: DATA_W] = DATA_W'(blkSum[c] >> modelK);
            expData.push_back(d);
            expErr.push_back(blkErr);
            lastExpData = d;
            blkFrames   = 0;
            blkErr      = 1'b0;
            for (int c = 0; c < NUM_CH; c++) blkSum[c] = 0;
        end
    endtask

    // Run the queued frames through the DUT and compare every published block with the model
    task automatic applyStimulus(input int kReq, input bit single, input int nUpd);
        int    baseUpd;
        int    baseFalls;
        int    budget;
        int    nExp;
        data_t ed;
        logic  ee;
        baseUpd   = updCount;
        baseFalls = csFalls;
        updData.delete();
        updErr.delete();
        avgLog2 = AVG_W'(kReq);
        mode    = single;
        en      = 1'b1;
        if (single) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        budget = 0;
        while (updCount < baseUpd + nUpd && budget < nUpd * 3000) begin
            @(negedge clk);
            budget++;
            if (single && budget == 200) begin
                checkOutput("busy_midblock", busy, 1);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        if (!single) en = 1'b0;
        checkOutput("update_timeout", updCount >= baseUpd + nUpd, 1);
        budget = 0;
        while (busy && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("busy_fall", busy, 0);
        checkOutput("update_count", updCount - baseUpd, nUpd);
        checkOutput("frame_count", csFalls - baseFalls, framesPushed);
        nExp = expData.size();
        checkOutput("update_queue_len", updData.size(), nExp);
        for (int i = 0; i < nExp; i++) begin
            ed = expData.pop_front();
            ee = expErr.pop_front();
            if (updData.size() > 0) begin
                checkOutput("data_o", updData.pop_front(), ed);
                checkOutput("frame_err_o", updErr.pop_front(), ee);
            end
        end
    endtask

    // Directed and randomized scenarios, run back to back
    initial begin
        int   budget;
        int   baseUpd;
        int   baseFalls;
        int   kr;
        int   nb;
        rst_n   = 1'b0;
        en      = 1'b0;
        mode    = 1'b0;
        start   = 1'b0;
        avgLog2 = '0;
        spiBus.spi_miso_i = '0;
        repeat (3) @(negedge clk);
        checkOutput("cs_in_reset", spiBus.spi_cs_no, 1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("rst_cs", spiBus.spi_cs_no, 1);
        checkOutput("rst_sck", spiBus.spi_sck_o, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_update", dataUpdate, 0);
        checkOutput("rst_data", dataOut, 0);
        checkOutput("rst_err", frameErr, 0);

        $display("[TB] k=0 continuous, two frames");
        setK(0);
        pushFrame(mkFrame('0, {12'h123, 12'hABC}));
        pushFrame(mkFrame('0, {12'h456, 12'hBCD}));
        applyStimulus(0, 1'b0, 2);
        checkOutput("cs_low_clk", lastCsLow, CS_LOW_CLK);
        checkOutput("sck_rises", lastRises, FRAME_W);

        $display("[TB] k=2 average of four frames");
        setK(2);
        for (int i = 0; i < 4; i++)
            pushFrame(mkFrame('0, {DATA_W'($urandom_range(0, 4095)), DATA_W'(12'h100 + i)}));
        applyStimulus(2, 1'b0, 1);

        $display("[TB] exponent clamp with full-scale input");
        setK(3);
        for (int i = 0; i < 4; i++) pushFrame(mkFrame('0, {12'hFFF, 12'hFFF}));
        applyStimulus(3, 1'b0, 1);

        $display("[TB] leading-bit error then clean block");
        setK(1);
        pushFrame(mkFrame({4'b0100, 4'b0000}, rndData()));
        pushFrame(mkFrame('0, rndData()));
        pushFrame(mkFrame('0, rndData()));
        pushFrame(mkFrame('0, rndData()));
        applyStimulus(1, 1'b0, 2);

        $display("[TB] single-shot block with ignored mid-block start");
        setK(1);
        pushFrame(mkFrame('0, rndData()));
        pushFrame(mkFrame('0, rndData()));
        applyStimulus(1, 1'b1, 1);
        baseFalls = csFalls;
        repeat (300) @(negedge clk);
        checkOutput("ss_no_restart", csFalls - baseFalls, 0);
        checkOutput("ss_cs_idle", spiBus.spi_cs_no, 1);
        checkOutput("ss_busy_idle", busy, 0);
        en   = 1'b0;
        mode = 1'b0;

        $display("[TB] randomized continuous blocks");
        for (int r = 0; r < 4; r++) begin
            kr = $urandom_range(0, 3);
            nb = $urandom_range(1, 2);
            setK(kr);
            for (int f = 0; f < (nb << modelK); f++) pushFrame(mkFrame(rndLead(), rndData()));
            applyStimulus(kr, 1'b0, nb);
        end

        $display("[TB] enable dropped mid-frame");
        setK(1);
        txQ.push_back(mkFrame('0, rndData()));
        baseUpd   = updCount;
        baseFalls = csFalls;
        avgLog2   = AVG_W'(1);
        en        = 1'b1;
        budget    = 0;
        while (spiBus.spi_cs_no && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("endrop_cs_fall", spiBus.spi_cs_no, 0);
        repeat (40) @(negedge clk);
        checkOutput("endrop_in_frame", spiBus.spi_cs_no, 0);
        en     = 1'b0;
        budget = 0;
        while (busy && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        repeat (20) @(negedge clk);
        checkOutput("endrop_busy", busy, 0);
        checkOutput("endrop_no_update", updCount - baseUpd, 0);
        checkOutput("endrop_one_frame", csFalls - baseFalls, 1);
        checkOutput("endrop_cs_low_clk", lastCsLow, CS_LOW_CLK);
        checkOutput("endrop_sck_rises", lastRises, FRAME_W);
        checkOutput("endrop_data_held", dataOut, lastExpData);

        $display("[TB] asynchronous reset mid-frame");
        avgLog2 = '0;
        en      = 1'b1;
        budget  = 0;
        while (spiBus.spi_cs_no && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        repeat (30) @(negedge clk);
        checkOutput("midrst_in_frame", spiBus.spi_cs_no, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_cs", spiBus.spi_cs_no, 1);
        checkOutput("midrst_sck", spiBus.spi_sck_o, 1);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_update", dataUpdate, 0);
        checkOutput("midrst_data", dataOut, 0);
        checkOutput("midrst_err", frameErr, 0);
        en = 1'b0;
        #2;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("postrst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
